// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU: control codes, op classes, function
// fields, FSM state encodings and the ALUOp/funct control decoder.
package alu_pkg;

    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_INV = 3'b011;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_SLT = 3'b111;

    localparam logic [2:0] OP_LDST  = 3'b000;
    localparam logic [2:0] OP_BEQ   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Multiply and HI/LO moves deliberately decode to CTL_INV; the top routes them itself.
    function automatic logic [2:0] decode_ctl(input logic [2:0] alu_op, input logic [5:0] fn);
        logic [2:0] ctl;
        ctl = CTL_INV;
        case (alu_op)
            OP_LDST:  ctl = CTL_ADD;
            OP_BEQ:   ctl = CTL_SUB;
            OP_RTYPE: begin
                case (fn)
                    F_ADD:   ctl = CTL_ADD;
                    F_SUB:   ctl = CTL_SUB;
                    F_AND:   ctl = CTL_AND;
                    F_OR:    ctl = CTL_OR;
                    F_SLT:   ctl = CTL_SLT;
                    default: ctl = CTL_INV;
                endcase
            end
            default:  ctl = CTL_INV;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier, one multiplier bit per
// cycle LSB-first; done_o flags the final iteration with the full product on product_o.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 last_s;
    logic [2*WIDTH-1:0]   sum_s;

    assign last_s    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign sum_s     = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    assign busy_o    = busy_q;
    assign done_o    = last_s;
    assign product_o = sum_s;

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
        end else if (busy_q) begin
            busy_q   <= !last_s;
            cnt_q    <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            acc_q    <= sum_s;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        end else begin
            busy_q   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: decodes ALUOp/funct, executes single-cycle ops with a registered
// result, and runs MULT/MULTU through the iterative core into HI/LO.
module alu_ctrl_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic [2:0]       ALUCtl
);
    import alu_pkg::*;

    logic [1:0]         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sign_q, sign_d;

    logic [2:0]         alu_ctl_s;
    logic               is_mult_s, is_multu_s, is_mul_s, is_mfhi_s, is_mflo_s, invalid_s;
    logic               accept_s, mul_start_s, mul_busy_s, mul_done_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, alu_res_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;

    assign alu_ctl_s   = decode_ctl(ALUOp, funct);
    assign ALUCtl      = alu_ctl_s;
    assign is_mult_s   = (ALUOp == OP_RTYPE) && (funct == F_MULT);
    assign is_multu_s  = (ALUOp == OP_RTYPE) && (funct == F_MULTU);
    assign is_mfhi_s   = (ALUOp == OP_RTYPE) && (funct == F_MFHI);
    assign is_mflo_s   = (ALUOp == OP_RTYPE) && (funct == F_MFLO);
    assign is_mul_s    = is_mult_s || is_multu_s;
    assign invalid_s   = (alu_ctl_s == CTL_INV) && !(is_mul_s || is_mfhi_s || is_mflo_s);
    assign accept_s    = in_valid && in_ready_q;
    assign mul_start_s = accept_s && is_mul_s && (state_q == ST_IDLE);

    // The most-negative value's magnitude 2^(W-1) is exact as a W-bit unsigned number.
    assign mag_a_s    = (is_mult_s && op_a[WIDTH-1]) ? (-op_a) : op_a;
    assign mag_b_s    = (is_mult_s && op_b[WIDTH-1]) ? (-op_b) : op_b;
    assign prod_fix_s = sign_q ? (-prod_s) : prod_s;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start_s),
        .mcand_i   (mag_a_s),
        .mplier_i  (mag_b_s),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (prod_s)
    );

    // Single-cycle datapath, including HI/LO moves.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        if (is_mfhi_s) begin
            alu_res_s = hi_q;
        end else if (is_mflo_s) begin
            alu_res_s = lo_q;
        end else begin
            case (alu_ctl_s)
                CTL_ADD: alu_res_s = op_a + op_b;
                CTL_SUB: alu_res_s = op_a - op_b;
                CTL_AND: alu_res_s = op_a & op_b;
                CTL_OR:  alu_res_s = op_a | op_b;
                CTL_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                default: alu_res_s = {WIDTH{1'b0}};
            endcase
        end
    end

    // Handshake FSM; HI/LO are written on the last multiply iteration so DONE carries the pulse.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        sign_d      = sign_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (mul_start_s) begin
                    state_d    = ST_MUL;
                    in_ready_d = 1'b0;
                    sign_d     = is_mult_s && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res_s;
                    zero_d      = (alu_res_s == {WIDTH{1'b0}});
                    err_d       = invalid_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d     = ST_DONE;
                    hi_d        = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d        = prod_fix_s[WIDTH-1:0];
                    result_d    = prod_fix_s[WIDTH-1:0];
                    zero_d      = (prod_fix_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                end else if (!mul_busy_s) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            sign_q      <= sign_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Self-checking bench for alu_ctrl_exec: directed cases plus random traffic, all
// compared each cycle against a cycle-count/arithmetic reference model.
module tb_alu_ctrl_exec;
    localparam int W = 32;

    logic         clk, rst_n, in_valid, in_ready, out_valid, zero, err;
    logic [2:0]   ALUOp, ALUCtl;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b, result;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit           m_ready, m_valid, m_zero, m_err, m_active;
    logic [W-1:0] m_result, m_hi, m_lo;
    logic [63:0]  m_prod;
    int           m_cnt;

    alu_ctrl_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .result(result), .zero(zero), .err(err), .ALUCtl(ALUCtl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_ctl(input logic [2:0] aop, input logic [5:0] fn);
        if (aop == 3'b000) return 3'b010;
        if (aop == 3'b001) return 3'b110;
        if (aop == 3'b010) begin
            case (fn)
                6'b100000: return 3'b010;
                6'b100010: return 3'b110;
                6'b100100: return 3'b000;
                6'b100101: return 3'b001;
                6'b101010: return 3'b111;
                default:   return 3'b011;
            endcase
        end
        return 3'b011;
    endfunction

    task automatic model_reset();
        m_ready = 1; m_valid = 0; m_result = 0; m_zero = 0; m_err = 0;
        m_hi = 0; m_lo = 0; m_active = 0; m_cnt = 0; m_prod = 0;
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_edge();
        logic [63:0] sa, sb;
        m_valid = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == W) begin
                m_hi = m_prod[63:32]; m_lo = m_prod[31:0];
                m_valid = 1; m_result = m_lo; m_zero = (m_lo == 0); m_err = 0;
            end else if (m_cnt == W + 1) begin
                m_active = 0; m_ready = 1;
            end
        end else if (m_ready && in_valid) begin
            if (ALUOp == 3'b010 && (funct == 6'b011000 || funct == 6'b011001)) begin
                if (funct == 6'b011000) begin
                    sa = {{32{op_a[31]}}, op_a}; sb = {{32{op_b[31]}}, op_b};
                end else begin
                    sa = {32'd0, op_a}; sb = {32'd0, op_b};
                end
                m_prod = sa * sb;
                m_active = 1; m_cnt = 0; m_ready = 0;
            end else begin
                m_valid = 1; m_err = 0;
                case (ref_ctl(ALUOp, funct))
                    3'b010: m_result = op_a + op_b;
                    3'b110: m_result = op_a - op_b;
                    3'b000: m_result = op_a & op_b;
                    3'b001: m_result = op_a | op_b;
                    3'b111: m_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                    default: begin
                        if (ALUOp == 3'b010 && funct == 6'b010000)      m_result = m_hi;
                        else if (ALUOp == 3'b010 && funct == 6'b010010) m_result = m_lo;
                        else begin m_result = 0; m_err = 1; end
                    end
                endcase
                m_zero = (m_result == 0);
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_valid);
        chk("ALUCtl", ALUCtl, ref_ctl(ALUOp, funct));
        if (m_valid) begin
            chk("result", result, m_result);
            chk("zero", zero, m_zero);
            chk("err", err, m_err);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic v, input logic [2:0] aop, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v; ALUOp = aop; funct = fn; op_a = a; op_b = b;
    endtask

    // Issue one op while ready, wait (bounded) for its pulse, then for in_ready.
    task automatic do_op(input logic [2:0] aop, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res);
        int n;
        bit got;
        drive(1'b1, aop, fn, a, b);
        cycle();
        in_valid = 1'b0;
        got = 0; n = 0; res = 32'hDEAD_BEEF;
        while (!got && n < 40) begin
            if (out_valid) begin got = 1; res = result; end
            else begin cycle(); n++; end
        end
        chk("op_timeout", {63'd0, got}, 64'd1);
        n = 0;
        while (!in_ready && n < 5) begin cycle(); n++; end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r32, mul_res, add_res;
        int low, ov_at, add_at, j;
        bit got_add;
        logic [5:0] ftab [9];
        ftab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                 6'b011000, 6'b011001, 6'b010000, 6'b010010};

        rst_n = 1'b0;
        drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) cycle();
        chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0); chk("rst_zero", zero, 0); chk("rst_err", err, 0);
        rst_n = 1'b1;
        cycle();

        // ADD 7+5
        drive(1'b1, 3'b010, 6'b100000, 32'd7, 32'd5);
        #1 chk("add_ctl", ALUCtl, 3'b010);
        cycle();
        chk("add_valid", out_valid, 1); chk("add_result", result, 12); chk("add_zero", zero, 0);
        // SUB then SLT back-to-back
        drive(1'b1, 3'b010, 6'b100010, 32'd5, 32'd5);
        cycle();
        chk("sub_valid", out_valid, 1); chk("sub_result", result, 0); chk("sub_zero", zero, 1);
        drive(1'b1, 3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        cycle();
        chk("slt_valid", out_valid, 1); chk("slt_result", result, 1); chk("slt_zero", zero, 0);
        in_valid = 1'b0;
        cycle();

        // MULT -3*7: ready-low window and latency
        drive(1'b1, 3'b010, 6'b011000, 32'hFFFF_FFFD, 32'd7);
        cycle();
        in_valid = 1'b0;
        low = 0; ov_at = 0; mul_res = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) cycle();
            if (!in_ready) low++;
            if (out_valid) begin ov_at = k; mul_res = result; end
        end
        chk("mult_ready_low", low, 33); chk("mult_latency", ov_at, 33);
        chk("mult_lo", mul_res, 32'hFFFF_FFEB);
        do_op(3'b010, 6'b010000, 32'd0, 32'd0, r32); chk("mult_hi", r32, 32'hFFFF_FFFF);

        // MULTU with an ADD held during the busy window
        drive(1'b1, 3'b010, 6'b011001, 32'hFFFF_FFFF, 32'd2);
        cycle();
        drive(1'b1, 3'b010, 6'b100000, 32'd3, 32'd4);
        got_add = 0; ov_at = 0; add_at = 0; mul_res = 0; add_res = 0; j = 1;
        while (!got_add && j <= 40) begin
            if (out_valid) begin
                if (ov_at == 0) begin ov_at = j; mul_res = result; end
                else begin got_add = 1; add_at = j; add_res = result; in_valid = 1'b0; end
            end
            if (!got_add) begin cycle(); j++; end
        end
        in_valid = 1'b0;
        chk("multu_latency", ov_at, 33); chk("multu_lo", mul_res, 32'hFFFF_FFFE);
        chk("held_add_at", add_at, 35); chk("held_add_result", add_res, 7);
        do_op(3'b010, 6'b010000, 32'd0, 32'd0, r32); chk("multu_hi", r32, 1);

        // Illegal funct: HI/LO must survive
        drive(1'b1, 3'b010, 6'b111111, 32'd9, 32'd9);
        #1 chk("inv_ctl", ALUCtl, 3'b011);
        cycle();
        in_valid = 1'b0;
        chk("inv_valid", out_valid, 1); chk("inv_result", result, 0);
        chk("inv_err", err, 1); chk("inv_zero", zero, 1);
        do_op(3'b010, 6'b010000, 32'd0, 32'd0, r32); chk("inv_hi_kept", r32, 1);
        do_op(3'b010, 6'b010010, 32'd0, 32'd0, r32); chk("inv_lo_kept", r32, 32'hFFFF_FFFE);

        // Most-negative squared
        do_op(3'b010, 6'b011000, 32'h8000_0000, 32'h8000_0000, r32); chk("minsq_lo", r32, 0);
        do_op(3'b010, 6'b010000, 32'd0, 32'd0, r32); chk("minsq_hi", r32, 32'h4000_0000);

        // Reset at cycle 10 of a MULT
        drive(1'b1, 3'b010, 6'b011000, 32'd5, 32'd6);
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        rst_n = 1'b0;
        #1 chk("abort_ready", in_ready, 1); chk("abort_valid", out_valid, 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        repeat (40) cycle();
        do_op(3'b010, 6'b010010, 32'd0, 32'd0, r32); chk("abort_lo", r32, 0);
        do_op(3'b010, 6'b010000, 32'd0, 32'd0, r32); chk("abort_hi", r32, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            int fsel;
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      ALUOp = 3'b000;
            else if (r == 1) ALUOp = 3'b001;
            else if (r == 9) ALUOp = 3'($urandom_range(3, 7));
            else             ALUOp = 3'b010;
            fsel = $urandom_range(0, 10);
            funct = (fsel < 9) ? ftab[fsel] : 6'($urandom);
            op_a = pick(); op_b = pick();
            cycle();
        end
        in_valid = 1'b0;
        repeat (40) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
